button_event_classifier: RTL

//   Downstream of debounce_state_machine: consumes the clean debounced switch level and turns it into
//   one-cycle event pulses: press, release, single click, double click, long press, plus a held level.

---
 rtl/button_event_classifier_pkg.sv | 23 ++
 rtl/button_event_classifier_edge_detect.sv | 22 ++
 rtl/button_event_classifier.sv | 130 +++++++++++++
 3 files changed

// File: rtl/button_event_classifier_pkg.sv
// Shared state encodings and default timing
// constants for the button event path.
package button_event_classifier_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  localparam int DEF_LONG_CYC = 25_000_000;
  localparam int DEF_GAP_CYC  = 12_500_000;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_classifier_edge_detect.sv
// Registers the debounced level and exposes
// its rising and falling edges combinationally.
module button_event_classifier_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic db_level,
  output logic rise,
  output logic fall
);

  logic db_q;

  // previous-cycle copy of the level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) db_q <= 1'b0;
    else     db_q <= db_level;
  end

  assign rise = db_level & ~db_q;
  assign fall = ~db_level & db_q;

endmodule

// File: rtl/button_event_classifier.sv
// Turns a clean button level into press, release,
// click, double click and long press events.
module button_event_classifier
  import button_event_classifier_pkg::*;
#(
  parameter int LONG_CYC = DEF_LONG_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic db_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

  localparam int CNT_W =
    $clog2(max_int(LONG_CYC, GAP_CYC)) + 1;
  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYC - 1);

  logic             rise;
  logic             fall;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  button_event_classifier_edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .db_level (db_level),
    .rise     (rise),
    .fall     (fall)
  );

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  // raw edge pulses, one cycle after the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
    end
  end

  // gesture FSM with dwell counter and event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      held         <= 1'b0;
    end else begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      case (state)
        IDLE: begin
          held <= 1'b0;
          cnt  <= '0;
          if (rise) state <= PRESSED;
        end
        PRESSED: begin
          if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            held       <= 1'b1;
            cnt        <= '0;
            state      <= LONG_HELD;
          end else if (fall) begin
            cnt   <= '0;
            state <= WAIT_SECOND;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LONG_HELD: begin
          cnt <= '0;
          if (fall) begin
            held  <= 1'b0;
            state <= IDLE;
          end else begin
            held <= 1'b1;
          end
        end
        WAIT_SECOND: begin
          if (rise) begin
            cnt   <= '0;
            state <= SECOND_PRESSED;
          end else if (cnt == GAP_LAST) begin
            single_click <= 1'b1;
            cnt          <= '0;
            state        <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        SECOND_PRESSED: begin
          if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            held       <= 1'b1;
            cnt        <= '0;
            state      <= LONG_HELD;
          end else if (fall) begin
            double_click <= 1'b1;
            cnt          <= '0;
            state        <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          held  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
